// File: rtl/dplca_txop_tracker.sv
// dplca_txop_tracker: tracks TXOP claims per PLCA cycle, ages them over two windows
// and feeds per-TXOP update strobes to the DPLCA node-ID state machine.
module dplca_txop_tracker #(
   parameter int MAX_ID = 255,
   parameter int AGE_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dplca_aging,
   input  logic              beacon_det,
   input  logic              txop_end,
   input  logic              txop_active,
   input  logic [7:0]        curID,
   input  logic [AGE_W-1:0]  aging_cycles,
   output logic [MAX_ID:0]   txop_claim_table,
   output logic              dplca_txop_table_upd,
   output logic [7:0]        dplca_txop_id,
   output logic [7:0]        dplca_txop_node_count,
   output logic              dplca_new_age
);
   logic [MAX_ID:0]  cur_seen_q, cur_seen_d, prev_seen_q, prev_seen_d, table_q, table_d, cur_with;
   logic             act_sticky_q, act_sticky_d, age_pending_q, age_pending_d;
   logic             upd_q, upd_d, new_age_q, new_age_d;
   logic [7:0]       txop_cnt_q, txop_cnt_d, node_count_q, node_count_d, id_q, id_d, cnt_inc;
   logic [AGE_W-1:0] beacon_cnt_q, beacon_cnt_d, thr;
   logic [AGE_W:0]   bc_next;
   logic             claimed, close_win, swap;

   always_comb begin
      thr       = (aging_cycles == '0) ? AGE_W'(1) : aging_cycles;
      bc_next   = {1'b0, beacon_cnt_q} + (AGE_W+1)'(1);
      close_win = dplca_aging & beacon_det & (bc_next >= {1'b0, thr});
      swap      = dplca_aging & txop_end & (age_pending_q | close_win);
      claimed   = dplca_aging & txop_end & (act_sticky_q | txop_active);
      // IDs beyond MAX_ID shift the one-hot out of range and write nothing
      cur_with  = cur_seen_q | (claimed ? ((MAX_ID+1)'(1) << curID) : '0);
      cnt_inc   = (txop_cnt_q == 8'hFF) ? txop_cnt_q : txop_cnt_q + 8'd1;
      act_sticky_d  = dplca_aging & ~txop_end & (act_sticky_q | txop_active);
      cur_seen_d    = (!dplca_aging || swap) ? '0 : txop_end ? cur_with : cur_seen_q;
      prev_seen_d   = !dplca_aging ? '0 : swap ? cur_with : prev_seen_q;
      table_d       = !dplca_aging ? '0 : txop_end ? (prev_seen_q | cur_with) : table_q;
      txop_cnt_d    = (!dplca_aging || beacon_det) ? '0 : txop_end ? cnt_inc : txop_cnt_q;
      node_count_d  = !dplca_aging ? '0 : beacon_det ? (txop_end ? cnt_inc : txop_cnt_q) : node_count_q;
      beacon_cnt_d  = (!dplca_aging || close_win) ? '0 : beacon_det ? bc_next[AGE_W-1:0] : beacon_cnt_q;
      age_pending_d = dplca_aging & ~swap & (close_win | age_pending_q);
      new_age_d     = dplca_aging & (txop_end ? swap : new_age_q);
      upd_d         = txop_end;
      id_d          = txop_end ? curID : id_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_seen_q    <= '0;
         prev_seen_q   <= '0;
         table_q       <= '0;
         act_sticky_q  <= 1'b0;
         age_pending_q <= 1'b0;
         upd_q         <= 1'b0;
         new_age_q     <= 1'b0;
         txop_cnt_q    <= '0;
         node_count_q  <= '0;
         id_q          <= '0;
         beacon_cnt_q  <= '0;
      end else begin
         cur_seen_q    <= cur_seen_d;
         prev_seen_q   <= prev_seen_d;
         table_q       <= table_d;
         act_sticky_q  <= act_sticky_d;
         age_pending_q <= age_pending_d;
         upd_q         <= upd_d;
         new_age_q     <= new_age_d;
         txop_cnt_q    <= txop_cnt_d;
         node_count_q  <= node_count_d;
         id_q          <= id_d;
         beacon_cnt_q  <= beacon_cnt_d;
      end
   end

   assign txop_claim_table      = table_q;
   assign dplca_txop_table_upd  = upd_q;
   assign dplca_txop_id         = id_q;
   assign dplca_txop_node_count = node_count_q;
   assign dplca_new_age         = new_age_q;
endmodule
